// File: rtl/fast_serial_tx_arbiter_pkg.sv
// Shared types and constants for the fast-opto-serial transmit arbiter.
package fast_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    DEST  = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int   FRAME_BITS  = 10;
  localparam int   DATA_BITS   = FRAME_BITS - 2;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic DEST_PORT_A = 1'b0;
  localparam logic DEST_PORT_B = 1'b1;

  // Next round-robin index after idx, wrapping past last back to 0.
  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input logic [2:0] last);
    return (idx == last) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/fast_serial_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid request at or above the pointer wins, else lowest.
module rr_arbiter
  import fast_serial_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx,
  output logic            any
);

  logic [2:0] ptr;
  logic       found_hi;
  logic       found_lo;
  logic       hit_hi;
  logic       hit_lo;
  logic [2:0] idx_hi;
  logic [2:0] idx_lo;

  // Pointer moves just past the winner whenever a grant is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'd0;
    end else if (advance) begin
      ptr <= wrap_inc(grant_idx, 3'(NREQ - 1));
    end else begin
      ptr <= ptr;
    end
  end

  // Two priority scans: one restricted to indices >= ptr, one unrestricted for the wrap.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hit_hi   = 1'b0;
    hit_lo   = 1'b0;
    idx_hi   = 3'd0;
    idx_lo   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      hit_hi   = ~found_hi & req[i] & (3'(i) >= ptr);
      idx_hi   = hit_hi ? 3'(i) : idx_hi;
      found_hi = found_hi | hit_hi;
      hit_lo   = ~found_lo & req[i];
      idx_lo   = hit_lo ? 3'(i) : idx_lo;
      found_lo = found_lo | hit_lo;
    end
    grant_idx = found_hi ? idx_hi : idx_lo;
    any       = found_lo;
    grant     = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = found_lo & (grant_idx == 3'(i));
    end
  end

endmodule

// File: rtl/fast_serial_tx_arbiter.sv
// Shares the FTDI fast-serial TX link between NREQ byte requesters.
// Frame: start bit, 8 data bits LSB first, port-select bit, one stop cycle.
module fast_serial_tx_arbiter
  import fast_serial_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_dest,
  output logic [NREQ-1:0]   req_ready,
  input  logic              FSCTS,
  output logic              FSDI,
  output logic              FSCLK,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [CNT_W-1:0]  frame_count
);

  state_t          state;
  logic [7:0]      shift;
  logic            dest_lat;
  logic [2:0]      bit_cnt;
  logic [NREQ-1:0] grant;
  logic [2:0]      grant_idx;
  logic            any;
  logic            accept;
  logic [7:0]      sel_data;
  logic            sel_dest;

  assign FSCLK  = clk;
  assign accept = (state == IDLE) & FSCTS & any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // One-hot grant selects the byte and port bit to latch.
  always_comb begin
    sel_data = 8'h00;
    sel_dest = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sel_data = sel_data | (req_data[8*i +: 8] & {8{grant[i]}});
      sel_dest = sel_dest | (req_dest[i] & grant[i]);
    end
  end

  // Framing FSM; FSDI is registered so it reflects the state entered on each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      FSDI        <= IDLE_LEVEL;
      req_ready   <= '0;
      busy        <= 1'b0;
      grant_id    <= 3'd0;
      frame_count <= '0;
      shift       <= 8'h00;
      dest_lat    <= 1'b0;
      bit_cnt     <= 3'd0;
    end else begin
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= grant;
            shift     <= sel_data;
            dest_lat  <= sel_dest;
            grant_id  <= grant_idx;
            state     <= START;
            FSDI      <= 1'b0;
            busy      <= 1'b1;
          end else begin
            FSDI <= IDLE_LEVEL;
            busy <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= 3'd0;
          FSDI    <= shift[0];
        end
        DATA: begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state <= DEST;
            FSDI  <= dest_lat;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            FSDI    <= shift[bit_cnt + 3'd1];
          end
        end
        DEST: begin
          state       <= STOP;
          FSDI        <= IDLE_LEVEL;
          frame_count <= frame_count + CNT_W'(1);
        end
        STOP: begin
          state <= IDLE;
          FSDI  <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          FSDI  <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fast_serial_tx_arbiter.sv
// Scoreboarded bench: expected frames queued at stimulus, decoded from FSDI and compared.
module tb_fast_serial_tx_arbiter;

  localparam int NREQ  = 2;
  localparam int CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_dest = '0;
  logic [NREQ-1:0]   req_ready;
  logic              fscts = 1'b0;
  logic              fsdi;
  logic              fsclk;
  logic              busy;
  logic [2:0]        grant_id;
  logic [CNT_W-1:0]  frame_count;

  typedef struct {
    logic [7:0] data;
    logic       dest;
    logic [2:0] gid;
  } frame_t;

  frame_t exp_q[$];
  int     start_q[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     frames_seen = 0;
  int     exp_count = 0;
  int     cyc = 0;

  fast_serial_tx_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_dest    (req_dest),
    .req_ready   (req_ready),
    .FSCTS       (fscts),
    .FSDI        (fsdi),
    .FSCLK       (fsclk),
    .busy        (busy),
    .grant_id    (grant_id),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Serial decoder: start bit, 9 captured bits, stop bit checked against the scoreboard.
  initial begin
    int         mon_pos;
    logic [8:0] mon_bits;
    frame_t     f;
    mon_pos  = -1;
    mon_bits = 9'h000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mon_pos = -1;
      end else if (mon_pos < 0) begin
        if (fsdi === 1'b0) begin
          mon_pos = 0;
          start_q.push_back(cyc);
        end
      end else if (mon_pos < 9) begin
        mon_bits[mon_pos] = fsdi;
        mon_pos++;
      end else begin
        vectors++;
        frames_seen++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_unexpected: got data=%h dest=%b, required no frame", mon_bits[7:0], mon_bits[8]);
        end else begin
          f = exp_q.pop_front();
          if (mon_bits[7:0] !== f.data || mon_bits[8] !== f.dest || fsdi !== 1'b1 || grant_id !== f.gid) begin
            miscompares++;
            $display("FAIL frame: got data=%h dest=%b stop=%b gid=%0d, required data=%h dest=%b stop=1 gid=%0d",
                     mon_bits[7:0], mon_bits[8], fsdi, grant_id, f.data, f.dest, f.gid);
          end
        end
        mon_pos = -1;
      end
    end
  end

  task automatic do_reset();
    req_valid = '0;
    fscts     = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (fsdi !== 1'b1 || req_ready !== 2'b00 || busy !== 1'b0 || grant_id !== 3'd0 || frame_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_state: got fsdi=%b ready=%b busy=%b gid=%0d cnt=%0d, required 1 00 0 0 0",
               fsdi, req_ready, busy, grant_id, frame_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [10:0] seq;
    logic [10:0] exp_seq;
    int busy_cyc;
    int ready_cyc;
    bit got;
    exp_seq = 11'b11101001010;
    seq = '0; busy_cyc = 0; ready_cyc = 0; got = 1'b0;
    do_reset();
    req_data[7:0] = 8'hA5; req_dest = 2'b01; fscts = 1'b1; req_valid = 2'b01;
    exp_q.push_back('{data: 8'hA5, dest: 1'b1, gid: 3'd0});
    exp_count++;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL single_ready: got no ready within 10 cycles, required ready=01");
    end
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      seq[k] = fsdi;
      if (busy === 1'b1) busy_cyc++;
      if (req_ready === 2'b01) ready_cyc++;
      if (k == 0) req_valid = 2'b00;
    end
    @(negedge clk);
    vectors++;
    if (seq !== exp_seq) begin
      miscompares++;
      $display("FAIL single_seq: got %b, required %b (bit0 first)", seq, exp_seq);
    end
    vectors++;
    if (ready_cyc != 1 || busy_cyc != 11 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_timing: got ready_cycles=%0d busy_cycles=%0d busy_after=%b, required 1 11 0",
               ready_cyc, busy_cyc, busy);
    end
    vectors++;
    if (frame_count !== CNT_W'(exp_count) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_count: got cnt=%0d pending=%0d, required cnt=%0d pending=0", frame_count, exp_q.size(), exp_count);
    end
  endtask

  task automatic test_round_robin();
    int base;
    int grants;
    logic [1:0] exp_r;
    do_reset();
    start_q.delete();
    base = frames_seen;
    req_data = {8'h22, 8'h11}; req_dest = 2'b10; fscts = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{data: (i % 2 == 1) ? 8'h22 : 8'h11, dest: (i % 2 == 1), gid: 3'(i % 2)});
      exp_count++;
    end
    grants = 0;
    exp_r  = 2'b01;
    for (int t = 0; t < 100 && grants < 4; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        vectors++;
        if (req_ready !== exp_r) begin
          miscompares++;
          $display("FAIL rr_order: grant %0d got ready=%b, required %b", grants, req_ready, exp_r);
        end
        exp_r = ~exp_r;
        grants++;
        if (grants == 4) req_valid = 2'b00;
      end
    end
    vectors++;
    if (grants != 4) begin
      miscompares++;
      $display("FAIL rr_grants: got %0d grants, required 4", grants);
    end
    for (int t = 0; t < 40 && frames_seen < base + 4; t++) @(negedge clk);
    vectors++;
    if (start_q.size() != 4) begin
      miscompares++;
      $display("FAIL rr_starts: got %0d start bits, required 4", start_q.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (start_q[i] - start_q[i-1] != 12) begin
          miscompares++;
          $display("FAIL rr_spacing: got %0d cycles, required 12", start_q[i] - start_q[i-1]);
        end
      end
    end
    vectors++;
    if (frame_count !== CNT_W'(exp_count) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rr_count: got cnt=%0d pending=%0d, required cnt=%0d pending=0", frame_count, exp_q.size(), exp_count);
    end
  endtask

  task automatic test_flow_control();
    int base;
    int bad;
    do_reset();
    base = frames_seen;
    req_data = {8'h3C, 8'hA5}; req_dest = 2'b10; req_valid = 2'b11; fscts = 1'b0;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (fsdi !== 1'b1 || req_ready !== 2'b00 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL flow_hold: got %0d active cycles with FSCTS low, required 0", bad);
    end
    fscts = 1'b1;
    exp_q.push_back('{data: 8'hA5, dest: 1'b0, gid: 3'd0});
    exp_count++;
    @(negedge clk);
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL flow_grant: got ready=%b, required 01", req_ready);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    fscts = 1'b0;
    for (int t = 0; t < 20 && frames_seen < base + 1; t++) @(negedge clk);
    req_valid = 2'b10;
    bad = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00 || busy !== 1'b0) bad++;
    end
    req_valid = 2'b00;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL flow_hold2: got %0d active cycles with FSCTS low, required 0", bad);
    end
    vectors++;
    if (frames_seen != base + 1 || frame_count !== CNT_W'(exp_count) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL flow_count: got frames=%0d cnt=%0d, required frames=1 cnt=%0d", frames_seen - base, frame_count, exp_count);
    end
  endtask

  task automatic test_held_data();
    int base;
    bit got;
    do_reset();
    base = frames_seen;
    got = 1'b0;
    req_data[7:0] = 8'hA5; req_dest = 2'b00; req_valid = 2'b01; fscts = 1'b1;
    exp_q.push_back('{data: 8'hA5, dest: 1'b0, gid: 3'd0});
    exp_count++;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) got = 1'b1;
    end
    req_valid = 2'b00;
    @(negedge clk);
    req_data[7:0] = 8'hFF; req_dest = 2'b01;
    for (int t = 0; t < 20 && frames_seen < base + 1; t++) @(negedge clk);
    vectors++;
    if (!got || frames_seen != base + 1 || exp_q.size() != 0 || frame_count !== CNT_W'(exp_count)) begin
      miscompares++;
      $display("FAIL held_data: got ready=%b frames=%0d cnt=%0d, required ready seen, 1 frame, cnt=%0d",
               got, frames_seen - base, frame_count, exp_count);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    bit got;
    got = 1'b0;
    do_reset();
    req_data[7:0] = 8'hC3; req_dest = 2'b00; req_valid = 2'b01; fscts = 1'b1;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) got = 1'b1;
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (!got || fsdi !== 1'b1 || busy !== 1'b0 || frame_count !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_state: got ready_seen=%b fsdi=%b busy=%b cnt=%0d, required 1 1 0 0",
               got, fsdi, busy, frame_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    base = frames_seen;
    req_data = {8'h77, 8'h5A}; req_dest = 2'b11; req_valid = 2'b11;
    exp_q.push_back('{data: 8'h5A, dest: 1'b1, gid: 3'd0});
    exp_count++;
    got = 1'b0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        got = 1'b1;
        vectors++;
        if (req_ready !== 2'b01) begin
          miscompares++;
          $display("FAIL midreset_ptr: got ready=%b, required 01", req_ready);
        end
      end
    end
    req_valid = 2'b00;
    for (int t = 0; t < 20 && frames_seen < base + 1; t++) @(negedge clk);
    vectors++;
    if (!got || frames_seen != base + 1 || exp_q.size() != 0 || frame_count !== CNT_W'(exp_count)) begin
      miscompares++;
      $display("FAIL midreset_next: got ready_seen=%b frames=%0d cnt=%0d, required 1 1 %0d",
               got, frames_seen - base, frame_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    int base;
    int grants;
    int bad;
    logic [7:0] d;
    do_reset();
    base = frames_seen;
    d = 8'h01;
    req_data[7:0] = d; req_dest = 2'b00; req_valid = 2'b01; fscts = 1'b1;
    exp_q.push_back('{data: d, dest: 1'b0, gid: 3'd0});
    exp_count = (exp_count + 1) % 16;
    grants = 0;
    bad = 0;
    for (int t = 0; t < 400 && grants < 17; t++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        if (req_ready !== 2'b01) bad++;
        grants++;
        if (grants < 17) begin
          d = d + 8'h25;
          req_data[7:0] = d;
          exp_q.push_back('{data: d, dest: 1'b0, gid: 3'd0});
          exp_count = (exp_count + 1) % 16;
        end else begin
          req_valid = 2'b00;
        end
      end
    end
    for (int t = 0; t < 30 && frames_seen < base + 17; t++) @(negedge clk);
    vectors++;
    if (grants != 17 || bad != 0 || frames_seen != base + 17) begin
      miscompares++;
      $display("FAIL wrap_frames: got grants=%0d bad=%0d frames=%0d, required 17 0 17", grants, bad, frames_seen - base);
    end
    vectors++;
    if (frame_count !== CNT_W'(exp_count) || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_count: got cnt=%0d pending=%0d, required cnt=%0d pending=0", frame_count, exp_q.size(), exp_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_flow_control();
    test_held_data();
    test_reset_midframe();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
